mem_port_arbiter: RTL and testbench

- Shares one single-port synchronous SRAM between the core instruction-fetch port and the core data port.
- Each cycle at most one request is granted and driven onto the SRAM CE/WE/address/data pins; the response is returned one cycle later to the owning port.
- Sits between the core's instr/data request interfaces and the on-chip program/data RAM, in place of per-port memory glue.

---
 rtl/mem_port_arbiter.sv | 144 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-port arbiter sharing one single-port synchronous SRAM between the
// instruction-fetch and data ports. Optional conflict counter: MEM_ARB_PERF_EN.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH   = 14,
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_i,

    input  logic                      instr_req_i,
    input  logic [ADDR_WIDTH-1:0]     instr_addr_i,
    output logic                      instr_gnt_o,
    output logic                      instr_rvalid_o,
    output logic [DATA_WIDTH-1:0]     instr_rdata_o,

    input  logic                      data_req_i,
    input  logic                      data_we_i,
    input  logic [DATA_WIDTH/8-1:0]   data_be_i,
    input  logic [ADDR_WIDTH-1:0]     data_addr_i,
    input  logic [DATA_WIDTH-1:0]     data_wdata_i,
    output logic                      data_gnt_o,
    output logic                      data_rvalid_o,
    output logic [DATA_WIDTH-1:0]     data_rdata_o,

    output logic                      mem_ce_o,
    output logic                      mem_we_o,
    output logic [DATA_WIDTH/8-1:0]   mem_be_o,
    output logic [ADDR_WIDTH-1:0]     mem_addr_o,
    output logic [DATA_WIDTH-1:0]     mem_wdata_o,
    input  logic [DATA_WIDTH-1:0]     mem_rdata_i,

    output logic [31:0]               conflict_cnt_o
);

    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    // Response FSM: records which port owns the access issued last cycle.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RESP_I = 2'd1,
        RESP_D = 2'd2
    } resp_state_e;

    resp_state_e resp_state_q, resp_state_d;
    logic [3:0]  starve_cnt_q, starve_cnt_d;

    logic instr_win;
    logic instr_gnt;
    logic data_gnt;

    // Data normally wins a collision; a starved fetch takes the next slot.
    always_comb begin
        instr_win = instr_req_i & (~data_req_i | (starve_cnt_q == STARVE_MAX));
        instr_gnt = ~rst_i & instr_win;
        data_gnt  = ~rst_i & data_req_i & ~instr_win;
    end

    always_comb begin
        starve_cnt_d = 4'd0;
        if (instr_req_i && !instr_gnt) begin
            if (starve_cnt_q == STARVE_MAX) begin
                starve_cnt_d = STARVE_MAX;
            end else begin
                starve_cnt_d = starve_cnt_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            starve_cnt_q <= 4'd0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

    always_comb begin
        instr_gnt_o = instr_gnt;
        data_gnt_o  = data_gnt;
        mem_ce_o    = 1'b0;
        mem_we_o    = 1'b0;
        mem_be_o    = '0;
        mem_addr_o  = data_addr_i;
        mem_wdata_o = data_wdata_i;
        if (instr_gnt) begin
            mem_ce_o   = 1'b1;
            mem_addr_o = instr_addr_i;
        end else if (data_gnt) begin
            mem_ce_o = 1'b1;
            mem_we_o = data_we_i;
            mem_be_o = data_be_i;
        end
    end

    // Next state ignores the current state so grants can stream back-to-back.
    always_comb begin
        resp_state_d = IDLE;
        if (instr_gnt) begin
            resp_state_d = RESP_I;
        end else if (data_gnt) begin
            resp_state_d = RESP_D;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            resp_state_q <= IDLE;
        end else begin
            resp_state_q <= resp_state_d;
        end
    end

    always_comb begin
        instr_rvalid_o = ~rst_i & (resp_state_q == RESP_I);
        data_rvalid_o  = ~rst_i & (resp_state_q == RESP_D);
        instr_rdata_o  = mem_rdata_i;
        data_rdata_o   = mem_rdata_i;
    end

`ifdef MEM_ARB_PERF_EN
    logic [31:0] conflict_cnt_q, conflict_cnt_d;

    always_comb begin
        conflict_cnt_d = conflict_cnt_q;
        if (instr_req_i && data_req_i && (conflict_cnt_q != 32'hFFFF_FFFF)) begin
            conflict_cnt_d = conflict_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            conflict_cnt_q <= 32'd0;
        end else begin
            conflict_cnt_q <= conflict_cnt_d;
        end
    end

    assign conflict_cnt_o = conflict_cnt_q;
`else
    assign conflict_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: SRAM model, reference arbiter/memory model and
// a response scoreboard checked on the falling edge.
module tb_mem_port_arbiter;
  localparam int AW = 14;
  localparam int DW = 32;
  localparam int BW = DW / 8;
  localparam int LIMIT = 4;
  localparam int QW = DW + 3;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic rst_i = 1'b1;
  logic instr_req_i = 1'b0;
  logic [AW-1:0] instr_addr_i = '0;
  logic instr_gnt_o, instr_rvalid_o;
  logic [DW-1:0] instr_rdata_o;
  logic data_req_i = 1'b0;
  logic data_we_i = 1'b0;
  logic [BW-1:0] data_be_i = '0;
  logic [AW-1:0] data_addr_i = '0;
  logic [DW-1:0] data_wdata_i = '0;
  logic data_gnt_o, data_rvalid_o;
  logic [DW-1:0] data_rdata_o;
  logic mem_ce_o, mem_we_o;
  logic [BW-1:0] mem_be_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o;
  logic [DW-1:0] mem_rdata_i = '0;
  logic [31:0] conflict_cnt_o;

  mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(LIMIT)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i),
    .instr_gnt_o(instr_gnt_o), .instr_rvalid_o(instr_rvalid_o), .instr_rdata_o(instr_rdata_o),
    .data_req_i(data_req_i), .data_we_i(data_we_i), .data_be_i(data_be_i),
    .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i),
    .data_gnt_o(data_gnt_o), .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o),
    .mem_ce_o(mem_ce_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i),
    .conflict_cnt_o(conflict_cnt_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // ---------------- SRAM model (driven by DUT pins) ----------------
  logic [DW-1:0] sram [0:DEPTH-1];
  logic [DW-1:0] ref_mem [0:DEPTH-1];

  always @(posedge clk) begin
    if (mem_ce_o) begin
      if (mem_we_o) begin
        for (int b = 0; b < BW; b++)
          if (mem_be_o[b]) sram[mem_addr_o][8*b +: 8] <= mem_wdata_o[8*b +: 8];
      end else begin
        mem_rdata_i <= sram[mem_addr_o];
      end
    end
  end

  // ---------------- reference model + scoreboard ----------------
  logic [QW-1:0] exp_q[$];
  logic [QW-1:0] e;
  logic [3:0] m_starve = 4'd0;
  logic [31:0] m_conf = 32'd0;
  logic m_ig, m_dg, exp_iv, exp_dv, exp_chk;
  logic [DW-1:0] exp_rd;
  logic ig_seen = 1'b0;
  logic dg_seen = 1'b0;

  always @(negedge clk) begin
    check_eq("conflict_cnt", 64'(conflict_cnt_o), 64'(m_conf));
    if (rst_i) begin
      check_eq("reset_outputs",
               64'({instr_gnt_o, data_gnt_o, instr_rvalid_o, data_rvalid_o, mem_ce_o, mem_we_o}), 64'd0);
      exp_q.delete();
      m_starve = 4'd0;
      m_conf = 32'd0;
      ig_seen = 1'b0;
      dg_seen = 1'b0;
    end else begin
      exp_iv = 1'b0;
      exp_dv = 1'b0;
      exp_chk = 1'b0;
      exp_rd = '0;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        exp_chk = e[DW+2];
        exp_iv = (e[DW+1:DW] == 2'd1);
        exp_dv = (e[DW+1:DW] == 2'd2);
        exp_rd = e[DW-1:0];
      end
      check_eq("instr_rvalid", 64'(instr_rvalid_o), 64'(exp_iv));
      check_eq("data_rvalid", 64'(data_rvalid_o), 64'(exp_dv));
      if (exp_iv) check_eq("instr_rdata", 64'(instr_rdata_o), 64'(exp_rd));
      if (exp_dv && exp_chk) check_eq("data_rdata", 64'(data_rdata_o), 64'(exp_rd));

      m_ig = instr_req_i && (!data_req_i || m_starve == LIMIT);
      m_dg = data_req_i && !m_ig;
      check_eq("instr_gnt", 64'(instr_gnt_o), 64'(m_ig));
      check_eq("data_gnt", 64'(data_gnt_o), 64'(m_dg));
      check_eq("mem_ce", 64'(mem_ce_o), 64'(m_ig || m_dg));
      check_eq("mem_we", 64'(mem_we_o), 64'(m_dg && data_we_i));
      if (m_ig) begin
        check_eq("mem_addr_i", 64'(mem_addr_o), 64'(instr_addr_i));
        check_eq("mem_be_i", 64'(mem_be_o), 64'd0);
        exp_q.push_back({1'b1, 2'd1, ref_mem[instr_addr_i]});
      end
      if (m_dg) begin
        check_eq("mem_addr_d", 64'(mem_addr_o), 64'(data_addr_i));
        if (data_we_i) begin
          check_eq("mem_be_d", 64'(mem_be_o), 64'(data_be_i));
          check_eq("mem_wdata", 64'(mem_wdata_o), 64'(data_wdata_i));
          for (int b = 0; b < BW; b++)
            if (data_be_i[b]) ref_mem[data_addr_i][8*b +: 8] = data_wdata_i[8*b +: 8];
          exp_q.push_back({1'b0, 2'd2, {DW{1'b0}}});
        end else begin
          exp_q.push_back({1'b1, 2'd2, ref_mem[data_addr_i]});
        end
      end
      if (instr_req_i && !m_ig) m_starve = (m_starve == LIMIT) ? 4'(LIMIT) : m_starve + 4'd1;
      else m_starve = 4'd0;
`ifdef MEM_ARB_PERF_EN
      if (instr_req_i && data_req_i && m_conf != 32'hFFFF_FFFF) m_conf = m_conf + 32'd1;
`endif
      ig_seen = instr_gnt_o;
      dg_seen = data_gnt_o;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    instr_req_i = 1'b0;
    data_req_i = 1'b0;
    data_we_i = 1'b0;
    data_be_i = '0;
  endtask

  task automatic data_access(input logic we, input logic [AW-1:0] a,
                             input logic [DW-1:0] wd, input logic [BW-1:0] be);
    data_req_i = 1'b1;
    data_we_i = we;
    data_addr_i = a;
    data_wdata_i = wd;
    data_be_i = be;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [9:0] grant_pattern;
  logic [31:0] conf_exp;

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      sram[i] = 32'(i) * 32'h9E37_79B1;
      ref_mem[i] = 32'(i) * 32'h9E37_79B1;
    end
    sram[14'h10] = 32'hDEAD_BEEF;
    ref_mem[14'h10] = 32'hDEAD_BEEF;
    sram[14'h30] = 32'h1111_1111;
    ref_mem[14'h30] = 32'h1111_1111;

    // reset with requests pending: everything must stay quiet
    rst_i = 1'b1;
    instr_req_i = 1'b1;
    data_req_i = 1'b1;
    repeat (3) tick();
    idle_inputs();
    rst_i = 1'b0;
    tick();

    // single fetch
    instr_req_i = 1'b1;
    instr_addr_i = 14'h10;
    tick();
    instr_req_i = 1'b0;
    repeat (2) tick();

    // full-word store then load of the same word
    data_access(1'b1, 14'h20, 32'h1234_5678, 4'b1111);
    tick();
    data_access(1'b0, 14'h20, 32'h0, 4'b0000);
    tick();
    idle_inputs();
    repeat (2) tick();

    // byte store into 0x11111111, then read back 0x1111CC11
    data_access(1'b1, 14'h30, 32'hAABB_CCDD, 4'b0010);
    tick();
    data_access(1'b0, 14'h30, 32'h0, 4'b0000);
    tick();
    idle_inputs();
    repeat (2) tick();

    // continuous contention: fetch gets every fifth slot
    instr_req_i = 1'b1;
    instr_addr_i = 14'h40;
    for (int k = 0; k < 10; k++) begin
      data_access(1'b0, 14'(14'h50 + k), 32'h0, 4'b0000);
      tick();
      grant_pattern[k] = ig_seen;
      if (ig_seen) instr_addr_i = instr_addr_i + 14'd1;
    end
    check_eq("starve_pattern", 64'(grant_pattern), 64'(10'b10000_10000));
    idle_inputs();
    repeat (2) tick();

    // reset in the cycle right after a fetch grant
    instr_req_i = 1'b1;
    instr_addr_i = 14'h10;
    tick();
    rst_i = 1'b1;
    data_req_i = 1'b1;
    repeat (2) tick();
    rst_i = 1'b0;
    idle_inputs();
    repeat (2) tick();

    // seven cycles of both ports requesting (fresh counter after reset)
    instr_req_i = 1'b1;
    instr_addr_i = 14'h60;
    for (int k = 0; k < 7; k++) begin
      data_access(1'b0, 14'(14'h70 + k), 32'h0, 4'b0000);
      tick();
      if (ig_seen) instr_addr_i = instr_addr_i + 14'd1;
    end
    idle_inputs();
    tick();
`ifdef MEM_ARB_PERF_EN
    conf_exp = 32'd7;
`else
    conf_exp = 32'd0;
`endif
    check_eq("conflict_total", 64'(conflict_cnt_o), 64'(conf_exp));
    tick();

    // random traffic; each requester holds its request until granted
    for (int c = 0; c < 400; c++) begin
      if (!instr_req_i || ig_seen) begin
        instr_req_i = 1'($urandom_range(0, 1));
        instr_addr_i = 14'($urandom_range(0, 63));
      end
      if (!data_req_i || dg_seen) begin
        data_access(1'($urandom_range(0, 1)), 14'($urandom_range(0, 63)),
                    $urandom, 4'($urandom_range(1, 15)));
        data_req_i = 1'($urandom_range(0, 1));
      end
      tick();
    end
    idle_inputs();
    repeat (3) tick();
    check_eq("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
